mult_seq_32: RTL and testbench

- Iterative shift-add multiplier for the KGP_RISC execute stage, one multiplier bit per clock.
- Sits directly upstream of the 32-bit 3:1 writeback select mux.
- result_lo drives one mux data input; done qualifies the writeback select for that cycle.
- Supports signed and unsigned operands. Full 2*WIDTH product is exposed as result_hi:result_lo.

---
 rtl/mult_seq_32.sv | 131 +++++++++++++
 tb/tb_mult_seq_32.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_32.sv
// mult_seq_32: iterative signed/unsigned shift-add multiplier, one multiplier bit per clock.
// Latency: done pulses WIDTH+1 edges after the edge that accepts start (fewer with early exit).
// Backpressure: start is ignored while busy; results hold until the next FINISH or reset.
// Optional early exit when the remaining multiplier is zero: define MULT_EARLY_EXIT_EN.
module mult_seq_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // Counter value seen on the last of the WIDTH RUN edges.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, pre-shifted by the counter
  logic [WIDTH-1:0]   mplier_q, mplier_d; // remaining multiplier bits
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   mag_a, mag_b;

  // Operand magnitudes; the most-negative value maps onto itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  always_comb begin
    mag_a = (signed_op && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    mag_b = (signed_op && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
  end

  // Next-state logic for the IDLE -> RUN -> FINISH sequence.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_d    = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
`ifdef MULT_EARLY_EXIT_EN
        // No set bits left means no further additions; skip straight to FINISH.
        if ((cnt_q == LAST_CNT) || (mplier_d == '0)) begin
          state_d = S_FINISH;
        end
`else
        if (cnt_q == LAST_CNT) begin
          state_d = S_FINISH;
        end
`endif
      end
      S_FINISH: begin
        res_d   = neg_q ? (~acc_q + 1'b1) : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_q    <= res_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_q[WIDTH-1:0];
  assign result_hi = res_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mult_seq_32.sv
// tb_mult_seq_32: directed plus randomized checks of mult_seq_32 against an arithmetic product model.
// Latency: each operation is timed in edges from the accepting edge to the done cycle.
// Backpressure: covers start while busy, start in the done cycle, and result hold.
module tb_mult_seq_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int compared;
  int mismatched;

  mult_seq_32 dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product from plain integer arithmetic.
  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Edges from the accepting edge to the edge that raises done.
  function automatic int model_lat(input logic [31:0] b, input logic s);
`ifdef MULT_EARLY_EXIT_EN
    logic [31:0] mag;
    mag = (s && b[31]) ? (32'd0 - b) : b;
    for (int i = 31; i >= 0; i--) begin
      if (mag[i]) return i + 2;
    end
    return 2;
`else
    return 33;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents an operation; the next rising edge is the accepting edge E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a = a; op_b = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen, bounded so a dead DUT cannot hang the run.
  task automatic wait_done(input int from, output int n);
    n = from;
    while (n < from + 100) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] exp;
    int n;
    exp = model_prod(a, b, s);
    launch(a, b, s);
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    wait_done(0, n);
    check({tag, " latency"}, 64'(n), 64'(model_lat(b, s)));
    check({tag, " product"}, {result_hi, result_lo}, exp);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] ra, rb;
    logic        rs;
    logic        seen_done;

    compared = 0; mismatched = 0;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
    #3;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", {result_hi, result_lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_op("unsigned_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("unsigned_max hi", 64'(result_hi), 64'hFFFF_FFFE);
    check("unsigned_max lo", 64'(result_lo), 64'h0000_0001);
    do_op("signed_m3x7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
    check("signed_m3x7 lo", 64'(result_lo), 64'hFFFF_FFEB);
    do_op("signed_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    check("signed_minmin hi", 64'(result_hi), 64'h4000_0000);
    do_op("signed_min_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op("zero_neg", 32'h0000_0000, 32'hFFFF_FFF0, 1'b1);
    do_op("early_9x5", 32'd9, 32'd5, 1'b0);
    check("early_9x5 lo", 64'(result_lo), 64'd45);
    do_op("early_b0", 32'h1234_5678, 32'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1, 0));
      if (i % 5 == 0) rb = rb >> $urandom_range(31, 0);
      do_op($sformatf("rand%0d", i), ra, rb, rs);
    end

    // A second start while busy must be dropped.
    launch(32'h1234_5678, 32'h8000_0001, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    op_a = 32'd3; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(5, n);
    check("repulse latency", 64'(n), 64'd33);
    check("repulse product", {result_hi, result_lo}, model_prod(32'h1234_5678, 32'h8000_0001, 1'b0));

    // Start held during the done cycle is accepted immediately.
    op_a = 32'd6; op_b = 32'd7; signed_op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy", 64'(busy), 64'd1);
    wait_done(0, n);
    check("b2b latency", 64'(n), 64'(model_lat(32'd7, 1'b0)));
    check("b2b lo", 64'(result_lo), 64'd42);
    check("b2b hi", 64'(result_hi), 64'd0);

    // Operand changes without start must not disturb the held result.
    for (int i = 0; i < 50; i++) begin
      op_a = $urandom; op_b = $urandom; signed_op = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      check("hold result", {result_hi, result_lo}, 64'd42);
      check("hold busy", 64'(busy), 64'd0);
    end

    // Asynchronous reset mid-operation.
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst result", {result_hi, result_lo}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst no_done", 64'(seen_done), 64'd0);
    do_op("after_rst", 32'hFFFF_FFF9, 32'd1000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
